// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, WIDTH cycles per add.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_shift;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s, co;
  logic             accept, last_bit;

  assign s         = a_sr[0] ^ b_sr[0] ^ carry;
  assign co        = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign res_shift = WIDTH'({s, res_sr} >> 1);
  // DONE behaves like IDLE for accepting a new request.
  assign accept    = start && (state != RUN);
  assign last_bit  = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= a_in;
      b_sr  <= b_in;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= co;
      cnt    <= cnt + CW'(1);
      res_sr <= res_shift;
      // On the MSB step, carry holds the carry into the MSB and co the carry out.
      if (last_bit) begin
        sum  <= res_shift;
        cout <= co;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  <= carry ^ co;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder: cycle-level request model feeds a result
// scoreboard that a negedge monitor drains on every done pulse.
module tb_serial_full_adder;
  localparam int WIDTH = 8;

  logic             clk, rst, start, cin;
  logic [WIDTH-1:0] a_in, b_in;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  serial_full_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .cout  (cout),
    .ovf   (ovf)
`else
    .cout  (cout)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } res_t;

  res_t exp_q[$];
  res_t held = '0;
  int   checks = 0;
  int   fails = 0;
  int   rem = 0;
  bit   mdl_done = 1'b0;
  int   rst_epoch = 0;
  int   seen_epoch = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic res_t refAdd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c);
    res_t r;
    logic [WIDTH:0] total;
    int sa, sb, sv;
    total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    sa = $signed(a);
    sb = $signed(b);
    sv = sa + sb + (c ? 1 : 0);
    r.s = total[WIDTH-1:0];
    r.c = total[WIDTH];
    r.v = (sv > ((1 << (WIDTH - 1)) - 1)) || (sv < -(1 << (WIDTH - 1)));
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Request model: accepts when no operation is outstanding, done follows WIDTH edges later.
  always @(posedge clk) begin
    if (rst) begin
      rem = 0;
      mdl_done = 1'b0;
      exp_q.delete();
      rst_epoch++;
    end else if (rem > 0) begin
      rem--;
      mdl_done = (rem == 0);
    end else begin
      mdl_done = 1'b0;
      if (start) begin
        exp_q.push_back(refAdd(a_in, b_in, cin));
        rem = WIDTH;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_epoch != seen_epoch) begin
      held = '0;
      seen_epoch = rst_epoch;
    end
    checkOutput("busy", 32'(busy), 32'(rem > 0));
    checkOutput("done", 32'(done), 32'(mdl_done));
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL done_without_request: got done=1 expected no pending result at %0t",
                 $time);
      end else begin
        held = exp_q.pop_front();
      end
    end
    checkOutput("sum", 32'(sum), 32'(held.s));
    checkOutput("cout", 32'(cout), 32'(held.c));
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("ovf", 32'(ovf), 32'(held.v));
`endif
  end

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    cin   = c;
    @(negedge clk);
    start = 1'b0;
    a_in  = WIDTH'($urandom);
    b_in  = WIDTH'($urandom);
    cin   = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    cin = 1'b0;
    idleCycles(2);
    rst = 1'b0;

    applyStimulus(8'hFF, 8'h01, 1'b0);
    idleCycles(WIDTH + 5);
    applyStimulus(8'h5A, 8'hA5, 1'b1);
    idleCycles(WIDTH + 1);
    applyStimulus(8'h12, 8'h34, 1'b0);
    idleCycles(WIDTH + 1);

    // A second request during RUN must be dropped.
    applyStimulus(8'h0F, 8'h01, 1'b0);
    idleCycles(3);
    applyStimulus(8'hAA, 8'hAA, 1'b0);
    idleCycles(WIDTH + 2);

    // Abort in the 4th RUN cycle, then a fresh request.
    applyStimulus(8'h55, 8'h22, 1'b0);
    idleCycles(3);
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    idleCycles(2);
    applyStimulus(8'h03, 8'h04, 1'b0);
    idleCycles(WIDTH + 2);

    // Held start re-accepts in every DONE cycle.
    start = 1'b1;
    a_in = 8'h01;
    b_in = 8'h01;
    cin = 1'b0;
    idleCycles(4 * (WIDTH + 1) + 2);
    start = 1'b0;
    idleCycles(WIDTH + 2);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      idleCycles($urandom_range(0, WIDTH + 1));
    end
    idleCycles(WIDTH + 3);

`ifdef SERIAL_ADDER_OVF_EN
    applyStimulus(8'h7F, 8'h01, 1'b0);
    idleCycles(WIDTH + 2);
    applyStimulus(8'hFF, 8'h01, 1'b0);
    idleCycles(WIDTH + 2);
`endif

    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
